snn_wb_ctrl: RTL and testbench
==============================

# snn_wb_ctrl

Wishbone slave front end for the SNN accelerator; it sits directly upstream of the inference core. It decodes host accesses at `WB_BASE` into three things:
- the control/parameter registers the core consumes;
- write strobes into the image SRAM and the two weight SRAM banks;
- a read-back path for the ten output spike counters.

It also tracks busy/done status around each inference run.

## Interface
Parameters:
- `WB_BASE`, 32'h3000_0000, base address of the block's 64 KiB window.
- `NUM_PIXELS`, 196, number of image bytes.
- `OUTPUTS`, 10, number of output neurons.
- `WEIGHTS`, 1960, number of weight bytes (`NUM_PIXELS*OUTPUTS`).
- `HALF_WEIGHTS`, 980, bank split point.
- `DEFAULT_TIMESTEPS`, 100, reset value of TIMESTEPS.

Ports (one clock; reset is asynchronous and active-low):
- `wb_clk_i` in 1: clock.
- `wb_rst_ni` in 1: async active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone classic strobe/cycle/write.
- `wbs_sel_i` in 4: byte lanes.
- `wbs_adr_i` in 32 / `wbs_dat_i` in 32: address / write data.
- `wbs_ack_o` out 1 / `wbs_dat_o` out 32: ack / read data.
- `img_csb_o`, `img_web_o` out 1: image SRAM port-0 chip select / write enable (active low).
- `img_addr_o` out 10 / `img_din_o` out 8: image SRAM address / data.
- `w0_csb_o`, `w0_web_o`, `w0_addr_o`[10], `w0_din_o`[8] out: weight bank 0 write port, same convention.
- `w1_csb_o`, `w1_web_o`, `w1_addr_o`[10], `w1_din_o`[8] out: weight bank 1 write port.
- `start_o` out 1: one-cycle inference start pulse.
- `set_seed_o` out 1: one-cycle seed load pulse.
- `beta_o` out 8, `vth_o` out 8, `timesteps_o` out 10, `seed_o` out 8: parameters to the core.
- `done_i` in 1: one-cycle inference-complete pulse from the core.
- `spike_cnt_i` in 8*OUTPUTS: packed counters; neuron n is bits [8n+7:8n].

## Operation
Address map uses offset = `wbs_adr_i - WB_BASE`. Any address outside the window is ignored and never acked.
- 0x000 CTRL (W):
  - bit0=1 → `start_o` pulse, only if not busy.
  - bit1=1 → `set_seed_o` pulse.
  - Reads return 0.
- 0x004 STATUS (R):
  - bit0 busy, bit1 done (sticky), bit2 err (sticky).
  - Writing 1 to bit1 or bit2 clears that bit.
- 0x008 PARAMS (RW): [7:0] beta, [15:8] vth. Byte lanes are honored.
- 0x00C TIMESTEPS (RW): [9:0]. Written only when sel[0] and sel[1] are both set.
- 0x010 SEED (RW): [7:0].
- 0x100 + 4n, n < OUTPUTS (R): {24'b0, spike count n}.
- 0x1000 + 4i, i < NUM_PIXELS (W): image byte i = dat[7:0]. Written only if sel[0].
- 0x4000 + 4w, w < WEIGHTS (W): weight byte w.
  - w < HALF_WEIGHTS → bank 0, address w.
  - Otherwise → bank 1, address w − HALF_WEIGHTS.
- SRAM windows read as 0.
- Unmapped offsets inside the window: acked, read 0, writes dropped.

Busy and done:
- busy sets on an accepted start and clears on `done_i`.
- `done_i` also sets done.
- If `done_i` and a CTRL start arrive in the same cycle: `done_i` wins, the start is dropped, and busy ends at 0.

Writes while busy:
- Writes to SRAM windows, PARAMS, TIMESTEPS or SEED while busy are acked, dropped, and set err.
- CTRL start while busy: dropped, sets err.
- STATUS writes always apply.

State machine has two states:
- IDLE: if `cyc&stb` and the address is in the window → ACK. Decode and side effects are registered on this edge.
- ACK: `wbs_ack_o`=1 for exactly this cycle, then return to IDLE unconditionally.

## Timing
- Request sampled at edge N; ack, read data, SRAM strobes and CTRL pulses are all valid during cycle N+1. Latency is 1 cycle.
- One ack per transaction. The minimum spacing is 2 cycles, so a held strobe cannot double-ack.
- SRAM csb/web are low for exactly the ack cycle; addr/din are stable in that cycle.
- `wbs_dat_o` = 0 whenever ack = 0.
- Reset values of every output:
  - ack 0, dat 0, all csb/web 1, all addr/din 0;
  - start/set_seed 0, beta 0, vth 0, seed 0, timesteps `DEFAULT_TIMESTEPS`;
  - busy/done/err 0.
- Reset mid-transaction: no ack is issued and all strobes return high immediately (async).

## Test plan
- Reset, then read offsets 0x008/0x00C/0x004 → 0x0, 100, 0x0. All csb/web = 1.
- Write 0x1000+4·195 data 0xA5 → `img_csb_o`=`img_web_o`=0, addr 195, din 0xA5, in the ack cycle only.
- Write weight w=979 and w=980 with data 0x11 / 0x22 → bank 0 addr 979 din 0x11, then bank 1 addr 0 din 0x22.
- Write CTRL=1 → one `start_o` pulse, STATUS=0x1. A second CTRL=1 → no pulse, STATUS=0x5. Then pulse `done_i` → STATUS=0x6. Write STATUS=0x6 → 0x0.
- Drive `spike_cnt_i` neuron 9 = 0x37 and read 0x124 → 0x00000037. Read 0x128 → 0.
- Hold `cyc`/`stb` for 6 cycles on one request → acks on cycles 2, 4, 6 only, never in consecutive cycles. Assert reset during the ACK cycle → ack drops in the same cycle.

Source files
------------

// File: rtl/snn_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : snn_wb_ctrl_if
//  Description : Wishbone classic slave bus bundle for the SNN front end.
//  Revision    : 1.0  initial release
// ============================================================================
interface snn_wb_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/snn_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snn_wb_ctrl
//  Description : Wishbone slave decoding control/status registers, image and
//                weight SRAM write strobes and spike counter read-back.
//  Revision    : 1.0  initial release
// ============================================================================
module snn_wb_ctrl #(
    parameter logic [31:0] WB_BASE           = 32'h3000_0000,
    parameter int unsigned NUM_PIXELS        = 196,
    parameter int unsigned OUTPUTS           = 10,
    parameter int unsigned WEIGHTS           = NUM_PIXELS * OUTPUTS,
    parameter int unsigned HALF_WEIGHTS      = 980,
    parameter int unsigned DEFAULT_TIMESTEPS = 100
) (
    input  wire logic                   wb_clk_i,
    input  wire logic                   wb_rst_ni,
    snn_wb_ctrl_if.slave                wb,
    output logic                        img_csb_o,
    output logic                        img_web_o,
    output logic [9:0]                  img_addr_o,
    output logic [7:0]                  img_din_o,
    output logic                        w0_csb_o,
    output logic                        w0_web_o,
    output logic [9:0]                  w0_addr_o,
    output logic [7:0]                  w0_din_o,
    output logic                        w1_csb_o,
    output logic                        w1_web_o,
    output logic [9:0]                  w1_addr_o,
    output logic [7:0]                  w1_din_o,
    output logic                        start_o,
    output logic                        set_seed_o,
    output logic [7:0]                  beta_o,
    output logic [7:0]                  vth_o,
    output logic [9:0]                  timesteps_o,
    output logic [7:0]                  seed_o,
    input  wire logic                   done_i,
    input  wire logic [8*OUTPUTS-1:0]   spike_cnt_i
);

    localparam logic [31:0] c_WIN_BYTES = 32'h0001_0000;
    localparam logic [31:0] c_SPK_WORD  = 32'h0000_0040;
    localparam logic [31:0] c_IMG_WORD  = 32'h0000_0400;
    localparam logic [31:0] c_WGT_WORD  = 32'h0000_1000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_ack;

    logic [31:0] w_off;
    logic [31:0] w_word;
    logic        w_in_win;
    logic        w_accept;
    logic        w_wr;
    logic        w_rd;

    logic        w_is_ctrl, w_is_status, w_is_params, w_is_ts, w_is_seed;
    logic [31:0] w_spk_idx, w_img_idx, w_wgt_idx, w_wgt_addr;
    logic        w_is_spk, w_is_img, w_is_wgt, w_wgt_hi;
    logic        w_guarded;
    logic        w_start_req, w_start_ok, w_err_set, w_cfg_we;
    logic [31:0] w_rdata;

    logic [31:0] r_rdata;
    logic        r_img_csb, r_w0_csb, r_w1_csb;
    logic [9:0]  r_img_addr, r_w0_addr, r_w1_addr;
    logic [7:0]  r_img_din, r_w0_din, r_w1_din;
    logic        r_start, r_set_seed;
    logic [7:0]  r_beta, r_vth, r_seed;
    logic [9:0]  r_ts;
    logic        r_busy, r_done, r_err;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Bus FSM: one ack cycle per accepted request, always back to IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: if (wb.wbs_cyc_i && wb.wbs_stb_i && w_in_win) w_state_nxt = S_ACK;
            S_ACK: begin
                w_ack       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address decode works on word offsets; byte address bits [1:0] are ignored.
    assign w_off    = wb.wbs_adr_i - WB_BASE;
    assign w_in_win = (w_off < c_WIN_BYTES);
    assign w_word   = {2'b00, w_off[31:2]};
    assign w_accept = (r_state == S_IDLE) && wb.wbs_cyc_i && wb.wbs_stb_i && w_in_win;
    assign w_wr     = w_accept && wb.wbs_we_i;
    assign w_rd     = w_accept && !wb.wbs_we_i;

    assign w_is_ctrl   = (w_word == 32'd0);
    assign w_is_status = (w_word == 32'd1);
    assign w_is_params = (w_word == 32'd2);
    assign w_is_ts     = (w_word == 32'd3);
    assign w_is_seed   = (w_word == 32'd4);

    // Underflow below a window base wraps high, so one compare bounds both ends.
    assign w_spk_idx  = w_word - c_SPK_WORD;
    assign w_img_idx  = w_word - c_IMG_WORD;
    assign w_wgt_idx  = w_word - c_WGT_WORD;
    assign w_is_spk   = (w_spk_idx < OUTPUTS);
    assign w_is_img   = (w_img_idx < NUM_PIXELS);
    assign w_is_wgt   = (w_wgt_idx < WEIGHTS);
    assign w_wgt_hi   = (w_wgt_idx >= HALF_WEIGHTS);
    assign w_wgt_addr = w_wgt_hi ? (w_wgt_idx - HALF_WEIGHTS) : w_wgt_idx;

    assign w_guarded   = w_is_params || w_is_ts || w_is_seed || w_is_img || w_is_wgt;
    assign w_start_req = w_wr && w_is_ctrl && wb.wbs_dat_i[0];
    assign w_start_ok  = w_start_req && !r_busy && !done_i;
    assign w_err_set   = (w_wr && w_guarded && r_busy) || (w_start_req && r_busy);
    assign w_cfg_we    = w_wr && !r_busy;

    always_comb begin
        w_rdata = 32'd0;
        if (w_is_status)      w_rdata = {29'd0, r_err, r_done, r_busy};
        else if (w_is_params) w_rdata = {16'd0, r_vth, r_beta};
        else if (w_is_ts)     w_rdata = {22'd0, r_ts};
        else if (w_is_seed)   w_rdata = {24'd0, r_seed};
        else if (w_is_spk) begin
            for (int n = 0; n < int'(OUTPUTS); n++) begin
                if (w_spk_idx == 32'(n)) w_rdata = {24'd0, spike_cnt_i[8*n +: 8]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered side effects; every strobe lives only in the ack cycle
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_rdata    <= 32'd0;
            r_img_csb  <= 1'b1;
            r_w0_csb   <= 1'b1;
            r_w1_csb   <= 1'b1;
            r_img_addr <= 10'd0;
            r_w0_addr  <= 10'd0;
            r_w1_addr  <= 10'd0;
            r_img_din  <= 8'd0;
            r_w0_din   <= 8'd0;
            r_w1_din   <= 8'd0;
            r_start    <= 1'b0;
            r_set_seed <= 1'b0;
            r_beta     <= 8'd0;
            r_vth      <= 8'd0;
            r_seed     <= 8'd0;
            r_ts       <= 10'(DEFAULT_TIMESTEPS);
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rdata    <= w_rd ? w_rdata : 32'd0;
            r_start    <= w_start_ok;
            r_set_seed <= w_wr && w_is_ctrl && wb.wbs_dat_i[1];
            r_img_csb  <= !(w_cfg_we && w_is_img && wb.wbs_sel_i[0]);
            r_w0_csb   <= !(w_cfg_we && w_is_wgt && !w_wgt_hi);
            r_w1_csb   <= !(w_cfg_we && w_is_wgt && w_wgt_hi);

            if (w_cfg_we && w_is_img && wb.wbs_sel_i[0]) begin
                r_img_addr <= w_img_idx[9:0];
                r_img_din  <= wb.wbs_dat_i[7:0];
            end
            if (w_cfg_we && w_is_wgt && !w_wgt_hi) begin
                r_w0_addr <= w_wgt_addr[9:0];
                r_w0_din  <= wb.wbs_dat_i[7:0];
            end
            if (w_cfg_we && w_is_wgt && w_wgt_hi) begin
                r_w1_addr <= w_wgt_addr[9:0];
                r_w1_din  <= wb.wbs_dat_i[7:0];
            end

            if (w_cfg_we && w_is_params && wb.wbs_sel_i[0]) r_beta <= wb.wbs_dat_i[7:0];
            if (w_cfg_we && w_is_params && wb.wbs_sel_i[1]) r_vth  <= wb.wbs_dat_i[15:8];
            if (w_cfg_we && w_is_ts && (wb.wbs_sel_i[1:0] == 2'b11)) r_ts <= wb.wbs_dat_i[9:0];
            if (w_cfg_we && w_is_seed) r_seed <= wb.wbs_dat_i[7:0];

            // A completion in the same cycle as a start leaves the core idle.
            if (done_i)          r_busy <= 1'b0;
            else if (w_start_ok) r_busy <= 1'b1;

            if (done_i)                                          r_done <= 1'b1;
            else if (w_wr && w_is_status && wb.wbs_dat_i[1])     r_done <= 1'b0;

            if (w_err_set)                                       r_err <= 1'b1;
            else if (w_wr && w_is_status && wb.wbs_dat_i[2])     r_err <= 1'b0;
        end
    end

    assign wb.wbs_ack_o = w_ack;
    assign wb.wbs_dat_o = r_rdata;

    assign img_csb_o   = r_img_csb;
    assign img_web_o   = r_img_csb;
    assign img_addr_o  = r_img_addr;
    assign img_din_o   = r_img_din;
    assign w0_csb_o    = r_w0_csb;
    assign w0_web_o    = r_w0_csb;
    assign w0_addr_o   = r_w0_addr;
    assign w0_din_o    = r_w0_din;
    assign w1_csb_o    = r_w1_csb;
    assign w1_web_o    = r_w1_csb;
    assign w1_addr_o   = r_w1_addr;
    assign w1_din_o    = r_w1_din;
    assign start_o     = r_start;
    assign set_seed_o  = r_set_seed;
    assign beta_o      = r_beta;
    assign vth_o       = r_vth;
    assign timesteps_o = r_ts;
    assign seed_o      = r_seed;

    assign w_unused = ^{wb.wbs_dat_i[31:16], wb.wbs_sel_i[3:2]};

endmodule
`default_nettype wire

// File: tb/tb_snn_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snn_wb_ctrl
//  Description : Randomised self-checking bench for snn_wb_ctrl against a
//                behavioural register/strobe model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snn_wb_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_wb_ctrl_if bus();

    logic       img_csb, img_web, w0_csb, w0_web, w1_csb, w1_web;
    logic [9:0] img_addr, w0_addr, w1_addr, timesteps;
    logic [7:0] img_din, w0_din, w1_din, beta, vth, seed;
    logic       start, set_seed;
    logic       done_i = 1'b0;
    logic [7:0] spk [10];
    logic [79:0] spike_cnt;

    always_comb begin
        spike_cnt = '0;
        for (int n = 0; n < 10; n++) spike_cnt[8*n +: 8] = spk[n];
    end

    snn_wb_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wb          (bus),
        .img_csb_o   (img_csb),
        .img_web_o   (img_web),
        .img_addr_o  (img_addr),
        .img_din_o   (img_din),
        .w0_csb_o    (w0_csb),
        .w0_web_o    (w0_web),
        .w0_addr_o   (w0_addr),
        .w0_din_o    (w0_din),
        .w1_csb_o    (w1_csb),
        .w1_web_o    (w1_web),
        .w1_addr_o   (w1_addr),
        .w1_din_o    (w1_din),
        .start_o     (start),
        .set_seed_o  (set_seed),
        .beta_o      (beta),
        .vth_o       (vth),
        .timesteps_o (timesteps),
        .seed_o      (seed),
        .done_i      (done_i),
        .spike_cnt_i (spike_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0] m_beta, m_vth, m_seed;
    logic [9:0] m_ts;
    logic       m_busy, m_done, m_err;

    // Expected effects of the access being modelled
    bit          e_ack, e_img, e_w0, e_w1, e_start, e_sp;
    int unsigned e_addr;
    logic [7:0]  e_din;
    logic [31:0] e_rd;

    task automatic model_reset();
        m_beta = 0; m_vth = 0; m_seed = 0; m_ts = 10'd100;
        m_busy = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_access(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, input bit dn);
        int unsigned off, a, idx;
        bit          guarded;
        off = adr - BASE;
        a   = off & 32'hFFFF_FFFC;
        e_ack = (off < 32'h1_0000);
        e_rd = 0; e_img = 0; e_w0 = 0; e_w1 = 0; e_start = 0; e_sp = 0; e_addr = 0; e_din = 0;
        if (e_ack) begin
            if (!we) begin
                if (a == 4)       e_rd = {29'd0, m_err, m_done, m_busy};
                else if (a == 8)  e_rd = {16'd0, m_vth, m_beta};
                else if (a == 12) e_rd = {22'd0, m_ts};
                else if (a == 16) e_rd = {24'd0, m_seed};
                else if (a >= 32'h100 && a < 32'h100 + 4*10) e_rd = {24'd0, spk[(a - 32'h100) / 4]};
            end else if (a == 0) begin
                if (dat[0]) begin
                    if (m_busy) m_err = 1;
                    else if (!dn) begin e_start = 1; m_busy = 1; end
                end
                e_sp = dat[1];
            end else if (a == 4) begin
                if (dat[1]) m_done = 0;
                if (dat[2]) m_err = 0;
            end else begin
                guarded = (a == 8) || (a == 12) || (a == 16) ||
                          (a >= 32'h1000 && a < 32'h1000 + 4*196) ||
                          (a >= 32'h4000 && a < 32'h4000 + 4*1960);
                if (guarded && m_busy) m_err = 1;
                else if (guarded) begin
                    if (a == 8) begin
                        if (sel[0]) m_beta = dat[7:0];
                        if (sel[1]) m_vth  = dat[15:8];
                    end else if (a == 12) begin
                        if (sel[1:0] == 2'b11) m_ts = dat[9:0];
                    end else if (a == 16) begin
                        m_seed = dat[7:0];
                    end else if (a < 32'h4000) begin
                        if (sel[0]) begin e_img = 1; e_addr = (a - 32'h1000) / 4; e_din = dat[7:0]; end
                    end else begin
                        idx = (a - 32'h4000) / 4;
                        e_din = dat[7:0];
                        if (idx < 980) begin e_w0 = 1; e_addr = idx; end
                        else           begin e_w1 = 1; e_addr = idx - 980; end
                    end
                end
            end
            if (dn) begin m_busy = 0; m_done = 1; end
        end
    endtask

    task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit dn, output logic [31:0] rd);
        bit got;
        int lat;
        model_access(we, adr, sel, dat, dn);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr; bus.wbs_sel_i = sel; bus.wbs_dat_i = dat;
        done_i = dn;
        got = 0; lat = 0; rd = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            done_i = 0;
            if (got && c == lat + 1) begin
                check_value("ack_single", bus.wbs_ack_o, 0);
                check_value("dat_idle", bus.wbs_dat_o, 0);
                check_value("strobes_idle", {img_csb, img_web, w0_csb, w0_web, w1_csb, w1_web}, 6'h3F);
                check_value("start_idle", start, 0);
            end
            if (!got && bus.wbs_ack_o) begin
                got = 1; lat = c; rd = bus.wbs_dat_o;
                check_value("ack_latency", lat, 0);
                check_value("img_csb", img_csb, !e_img);
                check_value("img_web", img_web, !e_img);
                if (e_img) begin
                    check_value("img_addr", img_addr, e_addr);
                    check_value("img_din", img_din, e_din);
                end
                check_value("w0_csb", {w0_csb, w0_web}, {!e_w0, !e_w0});
                check_value("w1_csb", {w1_csb, w1_web}, {!e_w1, !e_w1});
                if (e_w0) check_value("w0_addr_din", {w0_addr, w0_din}, {e_addr[9:0], e_din});
                if (e_w1) check_value("w1_addr_din", {w1_addr, w1_din}, {e_addr[9:0], e_din});
                check_value("start_pulse", start, e_start);
                check_value("set_seed_pulse", set_seed, e_sp);
                bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
            end
        end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        check_value("acked", got, e_ack);
        if (e_ack && !we) check_value("rdata", rd, e_rd);
        check_value("params_out", {beta, vth, seed}, {m_beta, m_vth, m_seed});
        check_value("timesteps_out", timesteps, m_ts);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 done_i = 1;
        @(posedge clk); #1 done_i = 0;
        m_busy = 0; m_done = 1;
    endtask

    task automatic check_reset_outputs();
        check_value("rst_ack_dat", {31'd0, bus.wbs_ack_o} | bus.wbs_dat_o, 0);
        check_value("rst_csb_web", {img_csb, img_web, w0_csb, w0_web, w1_csb, w1_web}, 6'h3F);
        check_value("rst_addr", {img_addr, w0_addr, w1_addr}, 0);
        check_value("rst_din", {img_din, w0_din, w1_din}, 0);
        check_value("rst_pulses", {start, set_seed}, 0);
        check_value("rst_params", {beta, vth, seed}, 0);
        check_value("rst_timesteps", timesteps, 100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int unsigned r, k;
        bit held_ok;

        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        for (int n = 0; n < 10; n++) spk[n] = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        check_reset_outputs();

        xfer(0, BASE + 32'h8, 4'hF, 0, 0, rd); check_value("rst_params_rd", rd, 32'h0);
        xfer(0, BASE + 32'hC, 4'hF, 0, 0, rd); check_value("rst_ts_rd", rd, 32'd100);
        xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd); check_value("rst_status_rd", rd, 32'h0);

        xfer(1, BASE + 32'h1000 + 4*195, 4'hF, 32'hA5, 0, rd);
        xfer(1, BASE + 32'h4000 + 4*979, 4'hF, 32'h11, 0, rd);
        xfer(1, BASE + 32'h4000 + 4*980, 4'hF, 32'h22, 0, rd);

        xfer(1, BASE, 4'hF, 32'h1, 0, rd);
        xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd); check_value("status_busy", rd, 32'h1);
        xfer(1, BASE, 4'hF, 32'h1, 0, rd);
        xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd); check_value("status_busy_err", rd, 32'h5);
        pulse_done();
        xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd); check_value("status_done_err", rd, 32'h6);
        xfer(1, BASE + 32'h4, 4'hF, 32'h6, 0, rd);
        xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd); check_value("status_cleared", rd, 32'h0);

        spk[9] = 8'h37;
        xfer(0, BASE + 32'h124, 4'hF, 0, 0, rd); check_value("spike9", rd, 32'h37);
        xfer(0, BASE + 32'h128, 4'hF, 0, 0, rd); check_value("spike_oob", rd, 32'h0);

        // Start and completion landing on the same edge
        xfer(1, BASE, 4'hF, 32'h1, 1, rd);
        xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd); check_value("done_beats_start", rd, 32'h2);
        xfer(1, BASE + 32'h4, 4'hF, 32'h6, 0, rd);

        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 10; n++) spk[n] = 8'($urandom);
            r = $urandom_range(0, 13);
            case (r)
                0:  xfer(0, BASE + 4*$urandom_range(0, 4), 4'hF, 0, 0, rd);
                1:  xfer(1, BASE + 32'h8, 4'($urandom), $urandom, 0, rd);
                2:  xfer(1, BASE + 32'hC, 4'($urandom), $urandom, 0, rd);
                3:  xfer(1, BASE + 32'h10, 4'hF, $urandom, 0, rd);
                4:  xfer(1, BASE + 32'h1000 + 4*$urandom_range(0, 195), 4'($urandom), $urandom, 0, rd);
                5:  xfer(1, BASE + 32'h4000 + 4*$urandom_range(0, 1959), 4'hF, $urandom, 0, rd);
                6:  xfer(0, BASE + 32'h100 + 4*$urandom_range(0, 11), 4'hF, 0, 0, rd);
                7:  xfer(1, BASE, 4'hF, $urandom_range(0, 3), 0, rd);
                8:  xfer(1, BASE + 32'h4, 4'hF, $urandom, 0, rd);
                9:  pulse_done();
                10: begin
                    k = $urandom_range(0, 3);
                    if (k == 0)      xfer(1'($urandom), BASE + 32'h200 + 4*$urandom_range(0, 100), 4'hF, $urandom, 0, rd);
                    else if (k == 1) xfer(1'($urandom), BASE + 32'h1000 + 4*$urandom_range(196, 300), 4'hF, $urandom, 0, rd);
                    else if (k == 2) xfer(1'($urandom), BASE + 32'h4000 + 4*$urandom_range(1960, 2500), 4'hF, $urandom, 0, rd);
                    else             xfer(1'($urandom), BASE + 32'hFFFC, 4'hF, $urandom, 0, rd);
                end
                11: begin
                    if ($urandom_range(0, 1) == 0) xfer(1'($urandom), BASE + 32'h1_0000 + ($urandom & 32'hFFFC), 4'hF, $urandom, 0, rd);
                    else                           xfer(1'($urandom), BASE - 32'h4, 4'hF, $urandom, 0, rd);
                end
                12: xfer(1, BASE, 4'hF, 32'h1, 1, rd);
                default: xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd);
            endcase
        end

        // Held request: acks every other cycle only
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
        bus.wbs_adr_i = BASE + 32'h4; bus.wbs_sel_i = 4'hF;
        held_ok = 1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            check_value("held_ack", bus.wbs_ack_o, (c % 2 == 1) ? 1 : 0);
        end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        pulse_done();
        xfer(1, BASE + 32'h4, 4'hF, 32'h6, 0, rd);

        // Reset asserted during the ack cycle of an image write
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
        bus.wbs_adr_i = BASE + 32'h1000 + 4*5; bus.wbs_sel_i = 4'hF; bus.wbs_dat_i = 32'h5A;
        @(posedge clk); #1;
        check_value("pre_rst_ack", {bus.wbs_ack_o, img_csb}, 2'b10);
        rst_n = 0;
        #1;
        check_value("rst_ack_drop", bus.wbs_ack_o, 0);
        check_value("rst_strobe_drop", {img_csb, img_web}, 2'b11);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check_reset_outputs();
        xfer(0, BASE + 32'h4, 4'hF, 0, 0, rd); check_value("rst2_status", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
